// File: rtl/cpu_stack_ctl.sv
// cpu_stack_ctl: operand-stack controller with a two-entry top-of-stack cache.
// Applies each retiring stage-4 pop/push pair to an internal synchronous RAM.
// It keeps tos0/tos1 equal to stack[sp-1] and stack[sp-2]. When that cache
// has to be reloaded from RAM, the controller stalls stage 4.
// Optional build macro: CPU_STACK_CTL_FASTPOP_EN. When it is defined, the
// N=1 pop cases use the shorter paths. Without it, every N>=1 accept runs a
// full refill.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | idle; accepts a retiring instruction
// RD0   | RAM address = sp-1
// RD1   | capture tos0 from RAM (unless only tos1 is refilled); address = sp-2
// CAP   | capture tos1 from RAM; return to RUN
module cpu_stack_ctl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 35
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  valid_4a,
  input  logic [10:0]           st__to_pop_4a,
  input  logic [2:0]            c__to_push_4a,
  input  logic [WIDTH-1:0]      st__to_push_4a,
  output logic                  st__stall,
  output logic [WIDTH-1:0]      st__tos0,
  output logic [WIDTH-1:0]      st__tos1,
  output logic [DEPTH_LOG2:0]   st__sp,
  output logic                  st__err_overflow,
  output logic                  st__err_underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  // Wide enough for sp, the 11-bit pop count and sp+1 without wrapping.
  localparam int CW = (DEPTH_LOG2 + 2 > 12) ? DEPTH_LOG2 + 2 : 12;

  typedef enum logic [1:0] {RUN, RD0, RD1, CAP} state_t;

  state_t                state;
  logic                  skip_tos0;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      ram_rdata;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;

  logic [CW-1:0]         sp_ext, n_ext, n_eff, base, depth_c;
  logic [DEPTH_LOG2:0]   sp_nxt;
  logic                  accept, underflow, overflow, p_req, p_eff;
  logic                  pop0, fast_swap, pop1_refill;
  logic                  sp_ge1, sp_ge2;

  assign sp_ext    = CW'(st__sp);
  assign n_ext     = CW'(st__to_pop_4a);
  assign depth_c   = CW'(DEPTH);
  assign accept    = valid_4a && (state == RUN);
  assign underflow = (n_ext > sp_ext);
  assign n_eff     = underflow ? sp_ext : n_ext;
  assign base      = sp_ext - n_eff;
  assign p_req     = |c__to_push_4a;
  // base never exceeds DEPTH, so a push overflows exactly when base == DEPTH.
  assign overflow  = p_req && (base >= depth_c);
  assign p_eff     = p_req && !overflow;
  assign sp_nxt    = (DEPTH_LOG2 + 1)'(base + CW'(p_eff));
  assign sp_ge1    = |st__sp;
  assign sp_ge2    = |st__sp[DEPTH_LOG2:1];
  assign st__stall = (state != RUN);

  // The path choice uses the effective counts, so a dropped push or a clipped pop follows its real path.
  assign pop0 = (n_eff == '0);
`ifdef CPU_STACK_CTL_FASTPOP_EN
  assign fast_swap   = (n_eff == CW'(1)) && p_eff;
  assign pop1_refill = (n_eff == CW'(1)) && !p_eff;
`else
  assign fast_swap   = 1'b0;
  assign pop1_refill = 1'b0;
`endif

  // Single RAM port: the push write in RUN, then the refill reads.
  always_comb begin
    ram_addr = base[DEPTH_LOG2-1:0];
    case (state)
      RD0:     ram_addr = st__sp[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
      RD1:     ram_addr = st__sp[DEPTH_LOG2-1:0] - DEPTH_LOG2'(2);
      default: ram_addr = base[DEPTH_LOG2-1:0];
    endcase
  end

  assign ram_we = accept && p_eff;

  // Stack RAM with a synchronous read. The contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= st__to_push_4a;
    ram_rdata <= mem[ram_addr];
  end

  // Controller FSM: sp and error bookkeeping, cache fast paths and refill sequencing.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state             <= RUN;
      skip_tos0         <= 1'b0;
      st__sp            <= '0;
      st__tos0          <= '0;
      st__tos1          <= '0;
      st__err_overflow  <= 1'b0;
      st__err_underflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            st__sp <= sp_nxt;
            if (underflow) st__err_underflow <= 1'b1;
            if (overflow)  st__err_overflow  <= 1'b1;
            if (pop0) begin
              if (p_eff) begin
                st__tos1 <= st__tos0;
                st__tos0 <= st__to_push_4a;
              end
            end else if (fast_swap) begin
              st__tos0 <= st__to_push_4a;
            end else if (pop1_refill) begin
              st__tos0  <= st__tos1;
              skip_tos0 <= 1'b1;
              state     <= RD1;
            end else begin
              skip_tos0 <= 1'b0;
              state     <= RD0;
            end
          end
        end
        RD0: state <= RD1;
        RD1: begin
          if (!skip_tos0) st__tos0 <= sp_ge1 ? ram_rdata : '0;
          state <= CAP;
        end
        CAP: begin
          st__tos1 <= sp_ge2 ? ram_rdata : '0;
          state    <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_stack_ctl.sv
// tb_cpu_stack_ctl: randomized scoreboard bench for cpu_stack_ctl. A queue
// model of the stack predicts sp, the top two entries, the sticky flags and
// the number of stall cycles for every accepted instruction.
module tb_cpu_stack_ctl;

  localparam int DL    = 10;
  localparam int W     = 35;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          valid_4a = 1'b0;
  logic [10:0]   pop_n = '0;
  logic [2:0]    push_sel = '0;
  logic [W-1:0]  push_val = '0;
  logic          stall;
  logic [W-1:0]  tos0, tos1;
  logic [DL:0]   sp;
  logic          err_of, err_uf;

  always #5 clk = ~clk;

  cpu_stack_ctl #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .valid_4a          (valid_4a),
    .st__to_pop_4a     (pop_n),
    .c__to_push_4a     (push_sel),
    .st__to_push_4a    (push_val),
    .st__stall         (stall),
    .st__tos0          (tos0),
    .st__tos1          (tos1),
    .st__sp            (sp),
    .st__err_overflow  (err_of),
    .st__err_underflow (err_uf)
  );

  typedef struct {
    int           sp;
    logic [W-1:0] t0;
    logic [W-1:0] t1;
    bit           uf;
    bit           of;
    int           stalls;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] stk[$];
  bit           m_uf, m_of;
  int           checks = 0;
  int           failures = 0;
  int           stall_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    return {3'($urandom_range(7, 0)), 32'($urandom())};
  endfunction

  // Reference model: pops, pushes and limits applied to a plain queue.
  function automatic exp_t model_apply(int n, int ps, logic [W-1:0] v);
    exp_t e;
    int   sz   = stk.size();
    int   neff = (n > sz) ? sz : n;
    bit   p    = (ps != 0);
    if (n > sz) m_uf = 1'b1;
    repeat (neff) void'(stk.pop_back());
    if (p && (stk.size() + 1 > DEPTH)) begin
      m_of = 1'b1;
      p    = 1'b0;
    end
    if (p) stk.push_back(v);
    e.sp = stk.size();
    e.t0 = (e.sp >= 1) ? stk[e.sp-1] : '0;
    e.t1 = (e.sp >= 2) ? stk[e.sp-2] : '0;
    e.uf = m_uf;
    e.of = m_of;
    if (neff == 0) e.stalls = 0;
`ifdef CPU_STACK_CTL_FASTPOP_EN
    else if (neff == 1) e.stalls = p ? 0 : 2;
`endif
    else e.stalls = 3;
    return e;
  endfunction

  // Monitor: count stall cycles after each accept, then compare once the controller is idle again.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b && exp_q.size() > 0) begin
      if (stall) begin
        stall_cnt++;
        if (stall_cnt > 8) begin
          checks++;
          failures++;
          $display("FAIL stall_timeout actual=%0d required<=3", stall_cnt);
          void'(exp_q.pop_front());
          stall_cnt = 0;
        end
      end else begin
        e = exp_q.pop_front();
        chk("sp",     64'(sp),     64'(e.sp));
        chk("tos0",   64'(tos0),   64'(e.t0));
        chk("tos1",   64'(tos1),   64'(e.t1));
        chk("err_uf", 64'(err_uf), 64'(e.uf));
        chk("err_of", 64'(err_of), 64'(e.of));
        chk("stalls", 64'(stall_cnt), 64'(e.stalls));
        stall_cnt = 0;
      end
    end
  end

  // Present one instruction. Called at a negedge and returns at the next negedge.
  // While the DUT stalls, junk is driven to show that it is ignored.
  task automatic issue(int n, int ps, logic [W-1:0] v);
    int guard = 0;
    while (stall === 1'b1 && guard < 20) begin
      valid_4a = 1'b1;
      pop_n    = 11'($urandom_range(2047, 0));
      push_sel = 3'($urandom_range(7, 0));
      push_val = rand_val();
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      failures++;
      $display("FAIL issue_wait actual=stalled required=idle");
    end
    valid_4a = 1'b1;
    pop_n    = 11'(n);
    push_sel = 3'(ps);
    push_val = v;
    @(posedge clk);
    exp_q.push_back(model_apply(n, ps, v));
    #1 valid_4a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r, n, ps, guard;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_sp",    64'(sp),    64'(0));
    chk("rst_tos0",  64'(tos0),  64'(0));
    chk("rst_tos1",  64'(tos1),  64'(0));
    chk("rst_of",    64'(err_of), 64'(0));
    chk("rst_uf",    64'(err_uf), 64'(0));
    rst_b = 1'b1;
    @(negedge clk);

    // Back-to-back pushes, N=1 pop, N=2 with push, underflow, push after underflow.
    issue(0, 1, 35'd5);
    issue(0, 2, 35'd7);
    issue(0, 7, 35'd9);
    issue(1, 0, rand_val());
    issue(0, 1, 35'd9);
    issue(2, 3, 35'h1_0000_00AA);
    issue(1, 0, '0);
    issue(3, 0, '0);
    issue(0, 1, 35'd4);

    repeat (300) begin
      r = $urandom_range(99, 0);
      if (r < 40)      n = 0;
      else if (r < 65) n = 1;
      else if (r < 85) n = 2;
      else if (r < 95) n = $urandom_range(6, 3);
      else             n = $urandom_range(40, 7);
      ps = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(7, 1);
      issue(n, ps, rand_val());
    end

    // Fill to DEPTH, overflow the next push, then reach stack[0] to show it was not overwritten.
    while (stk.size() < DEPTH) issue(0, $urandom_range(7, 1), rand_val());
    issue(0, 1, rand_val());
    issue(DEPTH - 1, 0, '0);
    issue(1, 0, '0);

    // Reset during RD1 of a full refill.
    issue(0, 1, 35'h11);
    issue(0, 1, 35'h22);
    issue(0, 1, 35'h33);
    issue(2, 0, '0);
    @(posedge clk);
    #1 rst_b = 1'b0;
    exp_q.delete();
    stall_cnt = 0;
    stk.delete();
    m_uf = 1'b0;
    m_of = 1'b0;
    #1;
    chk("rrst_stall", 64'(stall),  64'(0));
    chk("rrst_sp",    64'(sp),     64'(0));
    chk("rrst_tos0",  64'(tos0),   64'(0));
    chk("rrst_tos1",  64'(tos1),   64'(0));
    chk("rrst_of",    64'(err_of), 64'(0));
    chk("rrst_uf",    64'(err_uf), 64'(0));
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    issue(0, 1, 35'h4_0000_0044);
    issue(0, 5, 35'h55);
    issue(1, 0, '0);
    issue(1, 1, 35'h66);

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
